// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryptor: forward key schedule to K32, then 31 inverse rounds.
// Optional build macro PRESENT_DEC_KEY_CACHE_EN caches K32 per key so that a repeated key skips KEYEXP.
module present_decrypt_core #(
  parameter int unsigned NROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int unsigned BW  = 64;
  localparam int unsigned KW  = 80;
  localparam int unsigned RCW = 5;
  localparam logic [RCW-1:0] RC_LAST  = RCW'(NROUNDS);
  localparam logic [RCW-1:0] RC_FIRST = RCW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_DEC    = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward key update: rotl61, S-box on top nibble, round counter into bits 19:15.
  function automatic logic [KW-1:0] key_fwd(input logic [KW-1:0] k, input logic [RCW-1:0] rc);
    logic [KW-1:0] t;
    t         = {k[18:0], k[79:19]};
    t[79:76]  = sbox(t[79:76]);
    t[19:15]  = t[19:15] ^ rc;
    return t;
  endfunction

  // Exact inverse of key_fwd for the same round counter.
  function automatic logic [KW-1:0] key_inv(input logic [KW-1:0] k, input logic [RCW-1:0] rc);
    logic [KW-1:0] t;
    t         = k;
    t[19:15]  = t[19:15] ^ rc;
    t[79:76]  = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  function automatic logic [BW-1:0] dec_round(input logic [BW-1:0] s, input logic [BW-1:0] rk);
    logic [BW-1:0] x;
    logic [BW-1:0] y;
    logic [BW-1:0] z;
    logic [5:0]    p;
    x = s ^ rk;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      p        = 6'((16 * i) % 63);
      y[6'(i)] = x[p];
    end
    y[63] = x[63];
    z = '0;
    for (int n = 0; n < 16; n++) begin
      z[6'(4 * n) +: 4] = inv_sbox(y[6'(4 * n) +: 4]);
    end
    return z;
  endfunction

  state_t          r_state;
  logic [BW-1:0]   r_st;
  logic [KW-1:0]   r_kr;
  logic [RCW-1:0]  r_rc;
  logic [BW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_in_ready;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [BW-1:0]   w_st_nxt;
  logic [KW-1:0]   w_kr_nxt;
  logic [RCW-1:0]  w_rc_nxt;
  logic [BW-1:0]   w_out_data_nxt;
  logic            w_out_valid_nxt;
  logic [KW-1:0]   w_kr_fwd;
  logic [KW-1:0]   w_kr_inv;
  logic [BW-1:0]   w_st_dec;
  logic            w_accept;

  assign w_kr_fwd = key_fwd(r_kr, r_rc);
  assign w_kr_inv = key_inv(r_kr, r_rc);
  assign w_st_dec = dec_round(r_st, r_kr[79:16]);
  assign w_accept = in_valid && r_in_ready;

`ifdef PRESENT_DEC_KEY_CACHE_EN
  logic [KW-1:0] r_tag;
  logic [KW-1:0] r_cache;
  logic          r_cache_vld;
  logic          w_cache_hit;

  assign w_cache_hit = r_cache_vld && (in_key == r_tag);

  // Tag is captured at accept and only validated once K32 has been produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag       <= '0;
      r_cache     <= '0;
      r_cache_vld <= 1'b0;
    end else if (r_state == S_IDLE && w_accept && !w_cache_hit) begin
      r_tag       <= in_key;
      r_cache_vld <= 1'b0;
    end else if (r_state == S_KEYEXP && r_rc == RC_LAST) begin
      r_cache     <= w_kr_fwd;
      r_cache_vld <= 1'b1;
    end
  end
`endif

  // Next-state and datapath selection.
  always_comb begin
    w_state_nxt     = r_state;
    w_st_nxt        = r_st;
    w_kr_nxt        = r_kr;
    w_rc_nxt        = r_rc;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_st_nxt    = in_data;
          w_kr_nxt    = in_key;
          w_rc_nxt    = RC_FIRST;
          w_state_nxt = S_KEYEXP;
`ifdef PRESENT_DEC_KEY_CACHE_EN
          if (w_cache_hit) begin
            w_kr_nxt    = r_cache;
            w_rc_nxt    = RC_LAST;
            w_state_nxt = S_DEC;
          end
`endif
        end
      end
      S_KEYEXP: begin
        w_kr_nxt = w_kr_fwd;
        if (r_rc == RC_LAST) begin
          w_state_nxt = S_DEC;
        end else begin
          w_rc_nxt = r_rc + RCW'(1);
        end
      end
      S_DEC: begin
        w_st_nxt = w_st_dec;
        w_kr_nxt = w_kr_inv;
        w_rc_nxt = r_rc - RCW'(1);
        if (r_rc == RC_FIRST) begin
          w_state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        w_out_data_nxt  = r_st ^ r_kr[79:16];
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_kr        <= '0;
      r_rc        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_st        <= w_st_nxt;
      r_kr        <= w_kr_nxt;
      r_rc        <= w_rc_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_present_decrypt_core.sv
// Bench for present_decrypt_core: known-answer table, stall, reset abort, ignored input, key cache.
module tb_present_decrypt_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  typedef struct {
    logic [79:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  vec_t        vecs [4];
  logic [63:0] sb_q [$];
  int          n_cmp;
  int          n_bad;
  bit          m_vld;
  logic [79:0] m_tag;

  present_decrypt_core #(.NROUNDS(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_block(input logic [79:0] key, input logic [63:0] ct, input logic [63:0] pt,
                           input int stall, input bit garbage, input bit early_rdy);
    int          n;
    int          exp_lat;
    logic [63:0] exp_pt;
    logic [63:0] held;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 80'(in_ready), 80'd1);
    exp_lat = 63;
`ifdef PRESENT_DEC_KEY_CACHE_EN
    if (m_vld && key == m_tag) exp_lat = 32;
    m_vld = 1'b1;
    m_tag = key;
`endif
    in_valid = 1'b1;
    in_key   = key;
    in_data  = ct;
    sb_q.push_back(pt);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_key   = {16'($urandom), $urandom, $urandom};
    in_data  = {$urandom, $urandom};
    if (early_rdy) out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      if (garbage) begin
        in_valid = 1'($urandom);
        in_data  = {$urandom, $urandom};
        in_key   = {16'($urandom), $urandom, $urandom};
      end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("latency", 80'(n), 80'(exp_lat));
    check("scoreboard_depth", 80'(sb_q.size()), 80'd1);
    exp_pt = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    check("out_data", 80'(out_data), 80'(exp_pt));
    held = out_data;
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
      end
      check("hold_out_valid", 80'(out_valid), 80'd1);
      check("hold_out_data", 80'(out_data), 80'(held));
      check("hold_in_ready", 80'(in_ready), 80'd0);
      check("hold_busy", 80'(busy), 80'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 80'(out_valid), 80'd0);
    check("in_ready_return", 80'(in_ready), 80'd1);
    check("busy_drop", 80'(busy), 80'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    m_vld     = 1'b0;
    m_tag     = '0;
    vecs[0]   = '{key: 80'h0,                    ct: 64'h5579C1387B228445, pt: 64'h0000000000000000};
    vecs[1]   = '{key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'hE72C46C0F5945049, pt: 64'h0000000000000000};
    vecs[2]   = '{key: 80'h0,                    ct: 64'hA112FFC72F68417B, pt: 64'hFFFFFFFFFFFFFFFF};
    vecs[3]   = '{key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'h3333DCD3213210D2, pt: 64'hFFFFFFFFFFFFFFFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 80'(in_ready), 80'd1);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_out_data", 80'(out_data), 80'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort during DEC round 12; the aborted block must never produce output.
    in_valid = 1'b1;
    in_key   = vecs[1].key;
    in_data  = vecs[1].ct;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31 + 12) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 80'(busy), 80'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 80'(out_valid), 80'd0);
    check("abort_in_ready", 80'(in_ready), 80'd1);
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_out_data", 80'(out_data), 80'd0);
    m_vld = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, 0, 1'b0, 1'b0);
    end

    // Back-to-back with a 10-cycle downstream stall on the first block.
    run_block(vecs[2].key, vecs[2].ct, vecs[2].pt, 10, 1'b0, 1'b0);
    run_block(vecs[3].key, vecs[3].ct, vecs[3].pt, 0, 1'b0, 1'b0);

    // Garbage in_valid pulses while busy.
    run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 0, 1'b1, 1'b0);

    // out_ready already high before out_valid rises.
    run_block(vecs[1].key, vecs[1].ct, vecs[1].pt, 0, 1'b0, 1'b1);

    // Same key twice then a changed key (latency depends on build).
    run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 0, 1'b0, 1'b0);
    run_block(vecs[2].key, vecs[2].ct, vecs[2].pt, 0, 1'b0, 1'b0);
    run_block(vecs[3].key, vecs[3].ct, vecs[3].pt, 0, 1'b0, 1'b0);
    run_block(vecs[1].key, vecs[1].ct, vecs[1].pt, 3, 1'b1, 1'b0);

    check("scoreboard_empty", 80'(sb_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
